// File: rtl/debug_dump_sequencer_pkg.sv
// Shared definitions for the debug dump sequencer.
// Holds the default frame header byte, the FSM state encoding and small
// byte-count helpers used to size the serializer and the per-field byte counts.
package debug_dump_sequencer_pkg;

  localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_HDR      = 4'd1,
    ST_PC       = 4'd2,
    ST_CYC      = 4'd3,
    ST_REG_RD   = 4'd4,
    ST_REG_TX   = 4'd5,
    ST_MEM_RD   = 4'd6,
    ST_MEM_CHK  = 4'd7,
    ST_MADDR_TX = 4'd8,
    ST_MDATA_TX = 4'd9,
    ST_CSUM     = 4'd10,
    ST_DONE     = 4'd11
  } state_e;

  // Number of whole bytes needed to carry nbits (zero-extended).
  function automatic int bytes_for_bits(input int nbits);
    return (nbits + 7) / 8;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debug_dump_sequencer_if.sv
// Byte-wide UART transmit handshake.
//   tx_data  : byte to send, held stable while a byte is outstanding
//   tx_start : one-cycle send pulse from the sequencer
//   tx_done  : one-cycle byte-complete pulse from the UART
interface debug_dump_sequencer_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_done;

  modport master (output tx_data, output tx_start, input tx_done);
  modport slave  (input tx_data, input tx_start, output tx_done);
endinterface

// File: rtl/debug_dump_sequencer_serializer.sv
// dump_byte_serializer: loads a word plus a byte count and emits the bytes
// least-significant first, one tx_start per byte, waiting for tx_done between
// bytes. o_byte_done marks each accepted tx_done, o_last_done the final one.
// Ports: i_clock/i_reset (sync, active-high); i_load/i_word/i_nbytes load a
// field; o_tx_data/o_tx_start/i_tx_done UART handshake; o_byte_done/o_last_done.
module dump_byte_serializer #(
  parameter int NB_WORD = 32,
  parameter int NB_CNT  = 3
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_load,
  input  logic [NB_WORD-1:0] i_word,
  input  logic [NB_CNT-1:0]  i_nbytes,
  output logic [7:0]         o_tx_data,
  output logic               o_tx_start,
  input  logic               i_tx_done,
  output logic               o_byte_done,
  output logic               o_last_done
);

  logic [NB_WORD-1:0] shift_q, shift_d;
  logic [NB_CNT-1:0]  cnt_q, cnt_d;
  logic               wait_q, wait_d;
  logic               tx_start_q, tx_start_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               byte_done_s;

  // A tx_done only counts while a byte is outstanding; stray pulses are dropped.
  assign byte_done_s = i_tx_done & wait_q;
  assign o_byte_done = byte_done_s;
  assign o_last_done = byte_done_s & (cnt_q == NB_CNT'(1));
  assign o_tx_data   = tx_data_q;
  assign o_tx_start  = tx_start_q;

  // Next-state logic: load a new word or advance to the next byte.
  always_comb begin
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    wait_d     = wait_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    if (i_load) begin
      shift_d    = i_word;
      cnt_d      = i_nbytes;
      tx_data_d  = i_word[7:0];
      tx_start_d = 1'b1;
      wait_d     = 1'b1;
    end else if (byte_done_s) begin
      shift_d = shift_q >> 8;
      cnt_d   = cnt_q - NB_CNT'(1);
      if (cnt_q == NB_CNT'(1)) begin
        wait_d = 1'b0;
      end else begin
        tx_data_d  = shift_d[7:0];
        tx_start_d = 1'b1;
      end
    end else begin
      tx_start_d = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      shift_q    <= '0;
      cnt_q      <= '0;
      wait_q     <= 1'b0;
      tx_data_q  <= 8'h00;
      tx_start_q <= 1'b0;
    end else begin
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      wait_q     <= wait_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
    end
  end

endmodule

// File: rtl/debug_dump_sequencer.sv
// debug_dump_sequencer: on a start request, streams a debug frame over a UART
// byte handshake: HEADER, PC, cycle count, all registers, memory records
// (dirty words only, or every word) and an XOR checksum of all bytes after HEADER.
// Ports: i_clock/i_reset (sync, active-high); i_start/i_dump_all/i_pc/i_cycles
// request; o_reg_addr/i_reg_data register read; o_mem_addr/o_mem_rd/i_mem_data/
// i_mem_dirty memory read; tx_if UART handshake; o_busy/o_done status.
module debug_dump_sequencer
  import debug_dump_sequencer_pkg::*;
#(
  parameter int         NB_DATA     = 32,
  parameter int         NB_PC       = 32,
  parameter int         N_REGS      = 32,
  parameter int         MEM_DEPTH   = 128,
  parameter logic [7:0] HEADER      = HEADER_DEFAULT,
  localparam int        NB_REG_ADDR = $clog2(N_REGS),
  localparam int        NB_MEM_ADDR = $clog2(MEM_DEPTH)
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_start,
  input  logic                   i_dump_all,
  input  logic [NB_PC-1:0]       i_pc,
  input  logic [NB_DATA-1:0]     i_cycles,
  output logic [NB_REG_ADDR-1:0] o_reg_addr,
  input  logic [NB_DATA-1:0]     i_reg_data,
  output logic [NB_MEM_ADDR-1:0] o_mem_addr,
  output logic                   o_mem_rd,
  input  logic [NB_DATA-1:0]     i_mem_data,
  input  logic                   i_mem_dirty,
  debug_dump_sequencer_if.master tx_if,
  output logic                   o_busy,
  output logic                   o_done
);

  localparam int NB_WORD     = max_int(max_int(NB_DATA, NB_PC), 8);
  localparam int WORD_BYTES  = NB_WORD / 8;
  localparam int NB_CNT      = $clog2(WORD_BYTES + 1);
  localparam int PC_BYTES    = bytes_for_bits(NB_PC);
  localparam int DATA_BYTES  = bytes_for_bits(NB_DATA);
  localparam int MADDR_BYTES = bytes_for_bits(NB_MEM_ADDR);

  state_e                 state_q, state_d;
  logic [NB_PC-1:0]       pc_q, pc_d;
  logic [NB_DATA-1:0]     cyc_q, cyc_d;
  logic                   dump_all_q, dump_all_d;
  logic [7:0]             csum_q, csum_d;
  logic [NB_REG_ADDR-1:0] reg_addr_q, reg_addr_d;
  logic [NB_MEM_ADDR-1:0] mem_addr_q, mem_addr_d;
  logic [NB_DATA-1:0]     mem_word_q, mem_word_d;
  logic                   mem_rd_q, mem_rd_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   loaded_q, loaded_d;

  logic                   is_tx_s;
  logic                   ser_load_s;
  logic [NB_WORD-1:0]     ser_word_s;
  logic [NB_CNT-1:0]      ser_nbytes_s;
  logic [7:0]             ser_tx_data_s;
  logic                   ser_tx_start_s;
  logic                   ser_byte_done_s;
  logic                   ser_last_done_s;
  logic                   last_mem_s;

  dump_byte_serializer #(
    .NB_WORD (NB_WORD),
    .NB_CNT  (NB_CNT)
  ) u_serializer (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_load      (ser_load_s),
    .i_word      (ser_word_s),
    .i_nbytes    (ser_nbytes_s),
    .o_tx_data   (ser_tx_data_s),
    .o_tx_start  (ser_tx_start_s),
    .i_tx_done   (tx_if.tx_done),
    .o_byte_done (ser_byte_done_s),
    .o_last_done (ser_last_done_s)
  );

  assign tx_if.tx_data  = ser_tx_data_s;
  assign tx_if.tx_start = ser_tx_start_s;
  assign o_reg_addr     = reg_addr_q;
  assign o_mem_addr     = mem_addr_q;
  assign o_mem_rd       = mem_rd_q;
  assign o_busy         = busy_q;
  assign o_done         = done_q;
  assign last_mem_s     = (mem_addr_q == NB_MEM_ADDR'(MEM_DEPTH - 1));

  // Field presented to the serializer in each transmit state; loaded once on entry.
  always_comb begin
    is_tx_s      = 1'b1;
    ser_word_s   = '0;
    ser_nbytes_s = '0;
    case (state_q)
      ST_HDR:      begin ser_word_s = NB_WORD'(HEADER);     ser_nbytes_s = NB_CNT'(1);           end
      ST_PC:       begin ser_word_s = NB_WORD'(pc_q);       ser_nbytes_s = NB_CNT'(PC_BYTES);    end
      ST_CYC:      begin ser_word_s = NB_WORD'(cyc_q);      ser_nbytes_s = NB_CNT'(DATA_BYTES);  end
      ST_REG_TX:   begin ser_word_s = NB_WORD'(i_reg_data); ser_nbytes_s = NB_CNT'(DATA_BYTES);  end
      ST_MADDR_TX: begin ser_word_s = NB_WORD'(mem_addr_q); ser_nbytes_s = NB_CNT'(MADDR_BYTES); end
      ST_MDATA_TX: begin ser_word_s = NB_WORD'(mem_word_q); ser_nbytes_s = NB_CNT'(DATA_BYTES);  end
      ST_CSUM:     begin ser_word_s = NB_WORD'(csum_q);     ser_nbytes_s = NB_CNT'(1);           end
      default:     begin is_tx_s = 1'b0; end
    endcase
    ser_load_s = is_tx_s & ~loaded_q;
  end

  // FSM next state, datapath updates and registered output values.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cyc_d      = cyc_q;
    dump_all_d = dump_all_q;
    reg_addr_d = reg_addr_q;
    mem_addr_d = mem_addr_q;
    mem_word_d = mem_word_q;

    if (ser_load_s) begin
      loaded_d = 1'b1;
    end else if (ser_last_done_s) begin
      loaded_d = 1'b0;
    end else begin
      loaded_d = loaded_q;
    end

    // Header and the checksum byte itself are excluded from the XOR.
    if (ser_byte_done_s && (state_q != ST_HDR) && (state_q != ST_CSUM)) begin
      csum_d = csum_q ^ ser_tx_data_s;
    end else begin
      csum_d = csum_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          pc_d       = i_pc;
          cyc_d      = i_cycles;
          dump_all_d = i_dump_all;
          csum_d     = 8'h00;
          reg_addr_d = '0;
          mem_addr_d = '0;
          state_d    = ST_HDR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HDR: if (ser_last_done_s) state_d = ST_PC;     else state_d = ST_HDR;
      ST_PC:  if (ser_last_done_s) state_d = ST_CYC;    else state_d = ST_PC;
      ST_CYC: if (ser_last_done_s) state_d = ST_REG_RD; else state_d = ST_CYC;
      ST_REG_RD: state_d = ST_REG_TX;
      ST_REG_TX: begin
        if (!ser_last_done_s) begin
          state_d = ST_REG_TX;
        end else if (reg_addr_q == NB_REG_ADDR'(N_REGS - 1)) begin
          state_d = ST_MEM_RD;
        end else begin
          reg_addr_d = reg_addr_q + NB_REG_ADDR'(1);
          state_d    = ST_REG_RD;
        end
      end
      ST_MEM_RD: state_d = ST_MEM_CHK;
      ST_MEM_CHK: begin
        mem_word_d = i_mem_data;
        if (i_mem_dirty || dump_all_q) begin
          state_d = ST_MADDR_TX;
        end else if (last_mem_s) begin
          state_d = ST_CSUM;
        end else begin
          mem_addr_d = mem_addr_q + NB_MEM_ADDR'(1);
          state_d    = ST_MEM_RD;
        end
      end
      ST_MADDR_TX: if (ser_last_done_s) state_d = ST_MDATA_TX; else state_d = ST_MADDR_TX;
      ST_MDATA_TX: begin
        if (!ser_last_done_s) begin
          state_d = ST_MDATA_TX;
        end else if (last_mem_s) begin
          state_d = ST_CSUM;
        end else begin
          mem_addr_d = mem_addr_q + NB_MEM_ADDR'(1);
          state_d    = ST_MEM_RD;
        end
      end
      ST_CSUM: if (ser_last_done_s) state_d = ST_DONE; else state_d = ST_CSUM;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered so they line up with the state they describe.
    busy_d   = (state_d != ST_IDLE);
    done_d   = (state_d == ST_DONE);
    mem_rd_d = (state_d == ST_MEM_RD);
  end

  // State and datapath registers.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      pc_q       <= '0;
      cyc_q      <= '0;
      dump_all_q <= 1'b0;
      csum_q     <= 8'h00;
      reg_addr_q <= '0;
      mem_addr_q <= '0;
      mem_word_q <= '0;
      mem_rd_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      loaded_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      cyc_q      <= cyc_d;
      dump_all_q <= dump_all_d;
      csum_q     <= csum_d;
      reg_addr_q <= reg_addr_d;
      mem_addr_q <= mem_addr_d;
      mem_word_q <= mem_word_d;
      mem_rd_q   <= mem_rd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      loaded_q   <= loaded_d;
    end
  end

endmodule

// File: tb/tb_debug_dump_sequencer.sv
// Scoreboard bench for debug_dump_sequencer (N_REGS=4, NB_DATA=NB_PC=32,
// MEM_DEPTH=8). Expected frame bytes are queued when a dump is requested and
// compared as the UART model completes each byte.
module tb_debug_dump_sequencer;

  logic        clk = 1'b0;
  logic        i_reset, i_start, i_dump_all;
  logic [31:0] i_pc, i_cycles, i_reg_data, i_mem_data;
  logic        i_mem_dirty;
  logic [1:0]  o_reg_addr;
  logic [2:0]  o_mem_addr;
  logic        o_mem_rd, o_busy, o_done;

  debug_dump_sequencer_if tx_if ();

  debug_dump_sequencer #(
    .NB_DATA(32), .NB_PC(32), .N_REGS(4), .MEM_DEPTH(8), .HEADER(8'hA5)
  ) dut (
    .i_clock    (clk),
    .i_reset    (i_reset),
    .i_start    (i_start),
    .i_dump_all (i_dump_all),
    .i_pc       (i_pc),
    .i_cycles   (i_cycles),
    .o_reg_addr (o_reg_addr),
    .i_reg_data (i_reg_data),
    .o_mem_addr (o_mem_addr),
    .o_mem_rd   (o_mem_rd),
    .i_mem_data (i_mem_data),
    .i_mem_dirty(i_mem_dirty),
    .tx_if      (tx_if),
    .o_busy     (o_busy),
    .o_done     (o_done)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] regs [4];
  logic [31:0] mem_d [8];
  logic        dirty [8];
  logic [7:0]  exp_q [$];
  logic [7:0]  exp_csum;
  bit          sb_en = 1'b1;
  int          lat_max = 4;
  int          rx_total = 0;
  int          done_total = 0;
  int          start_total = 0;
  int          spur_req = 0;
  int          spur_ack = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_byte(input logic [7:0] b, input bit add);
    exp_q.push_back(b);
    if (add) exp_csum = exp_csum ^ b;
  endtask

  // Reference frame built from the request and the bench's register/memory contents.
  task automatic push_frame(input logic [31:0] pc, input logic [31:0] cyc, input logic dall);
    exp_csum = 8'h00;
    push_byte(8'hA5, 1'b0);
    for (int i = 0; i < 4; i++) push_byte(pc[8*i +: 8], 1'b1);
    for (int i = 0; i < 4; i++) push_byte(cyc[8*i +: 8], 1'b1);
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 4; i++) push_byte(regs[k][8*i +: 8], 1'b1);
    for (int a = 0; a < 8; a++) begin
      if (dirty[a] || dall) begin
        push_byte(8'(a), 1'b1);
        for (int i = 0; i < 4; i++) push_byte(mem_d[a][8*i +: 8], 1'b1);
      end
    end
    push_byte(exp_csum, 1'b0);
  endtask

  // Register file and memory with one cycle of read latency.
  initial begin
    logic [1:0] pra;
    logic [2:0] pma;
    logic       prd;
    pra = 2'd0; pma = 3'd0; prd = 1'b0;
    i_reg_data = 32'h0; i_mem_data = 32'h0; i_mem_dirty = 1'b0;
    forever begin
      @(negedge clk);
      i_reg_data = regs[pra];
      if (prd) begin
        i_mem_data  = mem_d[pma];
        i_mem_dirty = dirty[pma];
      end else begin
        i_mem_data  = 32'hBAD0BAD0;
        i_mem_dirty = 1'b1;
      end
      pra = o_reg_addr;
      pma = o_mem_addr;
      prd = o_mem_rd;
    end
  end

  // UART model: random per-byte latency, handshake and stability checks, scoreboard pop.
  initial begin
    bit         outstanding;
    logic [7:0] held;
    int         cnt;
    outstanding = 1'b0; held = 8'h00; cnt = 0;
    tx_if.tx_done = 1'b0;
    forever begin
      @(negedge clk);
      tx_if.tx_done = 1'b0;
      if (i_reset) begin
        outstanding = 1'b0;
      end else if (tx_if.tx_start) begin
        check_val("tx_start_while_outstanding", 32'(outstanding), 32'd0);
        outstanding = 1'b1;
        held = tx_if.tx_data;
        cnt = int'($urandom_range(lat_max, 1)) - 1;
      end else if (outstanding) begin
        check_val("tx_data_stable", 32'(tx_if.tx_data), 32'(held));
        if (cnt == 0) begin
          tx_if.tx_done = 1'b1;
          outstanding = 1'b0;
          rx_total++;
          if (sb_en) begin
            if (exp_q.size() == 0) check_val("sb_extra_byte", 32'(exp_q.size()), 32'd1);
            else check_val("sb_byte", 32'(held), 32'(exp_q.pop_front()));
          end
        end else begin
          cnt--;
        end
      end else if (spur_req != spur_ack) begin
        tx_if.tx_done = 1'b1;
        spur_ack++;
      end
    end
  end

  // Event counters.
  initial begin
    forever begin
      @(negedge clk);
      if (o_done) done_total++;
      if (tx_if.tx_start) start_total++;
    end
  end

  task automatic run_frame(input logic [31:0] pc, input logic [31:0] cyc, input logic dall,
                           input int exp_len, input bit mid_start);
    int b_done, b_rx, b_st, k;
    b_done = done_total; b_rx = rx_total; b_st = start_total;
    push_frame(pc, cyc, dall);
    i_pc = pc; i_cycles = cyc; i_dump_all = dall; i_start = 1'b1;
    tick(1);
    i_start = 1'b0; i_pc = ~pc; i_cycles = ~cyc; i_dump_all = ~dall;
    check_val("busy_after_start", 32'(o_busy), 32'd1);
    if (mid_start) begin
      k = 0;
      while ((start_total - b_st) < 10 && k < 5000) begin tick(1); k++; end
      check_val("reached_reg_tx", 32'((start_total - b_st) >= 10), 32'd1);
      i_start = 1'b1;
      tick(1);
      i_start = 1'b0;
    end
    k = 0;
    while (done_total == b_done && k < 40000) begin tick(1); k++; end
    if (done_total == b_done) check_val("done_timeout", 32'(done_total - b_done), 32'd1);
    tick(3);
    check_val("frame_len", 32'(rx_total - b_rx), 32'(exp_len));
    check_val("starts_eq_dones", 32'(start_total - b_st), 32'(rx_total - b_rx));
    check_val("done_pulses", 32'(done_total - b_done), 32'd1);
    check_val("sb_left", 32'(exp_q.size()), 32'd0);
    check_val("busy_after_done", 32'(o_busy), 32'd0);
    exp_q.delete();
  endtask

  task automatic mem_clean();
    for (int a = 0; a < 8; a++) begin
      mem_d[a] = $urandom;
      dirty[a] = 1'b0;
    end
  endtask

  initial begin
    int b_st, b_rx, k;
    for (int r = 0; r < 4; r++) regs[r] = 32'(32'h11223344 * r);
    mem_clean();
    i_reset = 1'b1; i_start = 1'b0; i_dump_all = 1'b0;
    i_pc = 32'h0; i_cycles = 32'h0;
    tick(3);
    check_val("rst_busy", 32'(o_busy), 32'd0);
    check_val("rst_done", 32'(o_done), 32'd0);
    check_val("rst_tx_start", 32'(tx_if.tx_start), 32'd0);
    check_val("rst_tx_data", 32'(tx_if.tx_data), 32'd0);
    check_val("rst_mem_rd", 32'(o_mem_rd), 32'd0);
    check_val("rst_reg_addr", 32'(o_reg_addr), 32'd0);
    check_val("rst_mem_addr", 32'(o_mem_addr), 32'd0);
    i_reset = 1'b0;
    tick(2);

    // Reset wins over a simultaneous start.
    i_reset = 1'b1; i_start = 1'b1;
    tick(1);
    i_reset = 1'b0; i_start = 1'b0;
    check_val("rst_prio_busy", 32'(o_busy), 32'd0);
    tick(1);
    check_val("rst_prio_no_frame", 32'(o_busy), 32'd0);

    // No dirty words: 26-byte frame.
    lat_max = 4;
    run_frame(32'h00000010, 32'h00000007, 1'b0, 26, 1'b0);

    // Dirty words 3 and 7: two records, 36 bytes.
    lat_max = 8;
    mem_d[3] = 32'hDEADBEEF; dirty[3] = 1'b1;
    mem_d[7] = 32'hCAFEF00D; dirty[7] = 1'b1;
    run_frame(32'h00000010, 32'h00000007, 1'b0, 36, 1'b0);

    // Dump every word with long random UART latency: 8 records, 66 bytes.
    lat_max = 200;
    mem_clean();
    dirty[2] = 1'b1;
    run_frame(32'h89ABCDEF, 32'h01234567, 1'b1, 66, 1'b0);

    // Start during register transmit is ignored; then a stray tx_done while idle.
    lat_max = 6;
    mem_clean();
    run_frame(32'h00000010, 32'h00000007, 1'b0, 26, 1'b1);
    b_st = start_total;
    spur_req++;
    tick(10);
    check_val("spurious_no_start", 32'(start_total - b_st), 32'd0);
    check_val("spurious_idle", 32'(o_busy), 32'd0);

    // Reset during the third PC byte, then a clean frame.
    sb_en = 1'b0;
    b_st = start_total;
    i_pc = 32'h55667788; i_cycles = 32'h1; i_dump_all = 1'b0; i_start = 1'b1;
    tick(1);
    i_start = 1'b0;
    k = 0;
    while ((start_total - b_st) < 4 && k < 5000) begin tick(1); k++; end
    check_val("reached_pc_byte2", 32'(start_total - b_st), 32'd4);
    i_reset = 1'b1;
    tick(1);
    check_val("midrst_busy", 32'(o_busy), 32'd0);
    check_val("midrst_tx_start", 32'(tx_if.tx_start), 32'd0);
    check_val("midrst_tx_data", 32'(tx_if.tx_data), 32'd0);
    tick(1);
    i_reset = 1'b0;
    b_rx = rx_total;
    tick(300);
    check_val("midrst_quiet", 32'(rx_total - b_rx), 32'd0);
    sb_en = 1'b1;
    run_frame(32'h00000010, 32'h00000007, 1'b0, 26, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/debug_dump_sequencer.md
DEBUG_DUMP_SEQUENCER -- requirements
Module: debug_dump_sequencer

Interface
REQ-001 The block SHALL expose parameter NB_DATA, default 32, giving the register, memory and cycle-count word width (multiple of 8).
REQ-002 The block SHALL expose parameter NB_PC, default 32, giving the PC width (multiple of 8).
REQ-003 The block SHALL expose parameter N_REGS, default 32, giving the number of registers dumped; NB_REG_ADDR = clog2(N_REGS).
REQ-004 The block SHALL expose parameter MEM_DEPTH, default 128, giving the number of data-memory words scanned; NB_MEM_ADDR = clog2(MEM_DEPTH).
REQ-005 The block SHALL expose parameter HEADER, default 8'hA5, giving the frame start byte.
REQ-006 i_clock  in  1  system clock; i_reset  in  1  synchronous, active-high reset.
REQ-007 i_start  in  1  dump request pulse; i_dump_all  in  1  1 = send every memory word, 0 = dirty words only (sampled at accepted start).
REQ-008 i_pc  in  NB_PC  PC snapshot; i_cycles  in  NB_DATA  cycle count (both captured at accepted start).
REQ-009 o_reg_addr  out  NB_REG_ADDR  register read address; i_reg_data  in  NB_DATA  register data, valid one cycle after o_reg_addr.
REQ-010 o_mem_addr  out  NB_MEM_ADDR  memory read address; o_mem_rd  out  1  memory debug-read enable; i_mem_data  in  NB_DATA, i_mem_dirty  in  1  both valid one cycle after o_mem_addr.
REQ-011 o_tx_data  out  8  byte to UART; o_tx_start  out  1  one-cycle send pulse; i_tx_done  in  1  one-cycle byte-complete pulse.
REQ-012 o_busy  out  1  dump in progress; o_done  out  1  one-cycle end-of-frame pulse.

Function
REQ-013 The FSM SHALL use states IDLE, HDR, PC, CYC, REG_RD, REG_TX, MEM_RD, MEM_CHK, MADDR_TX, MDATA_TX, CSUM, DONE.
REQ-014 IDLE: i_start=1 SHALL latch i_pc, i_cycles, i_dump_all, clear the checksum, and enter HDR next cycle; i_start SHALL be ignored in all other states.
REQ-015 Each transmitted byte SHALL be presented on o_tx_data with a single o_tx_start pulse; the next byte SHALL NOT be started before i_tx_done is seen; o_tx_data SHALL remain stable until i_tx_done.
REQ-016 Multi-byte fields SHALL be sent least-significant byte first.
REQ-017 Frame order SHALL be: HEADER; PC (NB_PC/8 bytes); cycles (NB_DATA/8); registers 0..N_REGS-1 (NB_DATA/8 each); memory records; checksum byte.
REQ-018 REG_RD SHALL drive o_reg_addr and wait one cycle before REG_TX captures i_reg_data into a shift register.
REQ-019 MEM_RD SHALL assert o_mem_rd and drive o_mem_addr; MEM_CHK (next cycle) SHALL capture i_mem_data and go to MADDR_TX if i_mem_dirty or the latched dump_all is set, else advance the address.
REQ-020 A memory record SHALL be the address (ceil(NB_MEM_ADDR/8) bytes, zero-extended) followed by the data word (NB_DATA/8 bytes).
REQ-021 After address MEM_DEPTH-1 the scan SHALL go to CSUM; addresses SHALL never wrap back to 0 within a frame.
REQ-022 The checksum SHALL be the 8-bit XOR of every byte after HEADER up to and excluding the checksum byte.
REQ-023 DONE SHALL pulse o_done for one cycle and return to IDLE; o_busy SHALL be 1 from the cycle after accepted start through DONE.
REQ-024 i_tx_done received while no byte is outstanding SHALL be ignored.
REQ-025 With no dirty words and i_dump_all=0, memory SHALL contribute zero bytes and the frame SHALL still close with CSUM.

Reset
REQ-026 i_reset SHALL force IDLE at any time, including mid-byte, and clear o_tx_start, o_busy, o_done, o_mem_rd, o_tx_data, o_reg_addr, o_mem_addr, the byte counter and the checksum to 0.
REQ-027 i_reset SHALL take priority over i_start in the same cycle.

Structure
REQ-028 The HEADER default, FSM state encodings and byte-count helper functions SHALL live in the shared parameters package.
REQ-029 One sub-module, dump_byte_serializer (load word, emit bytes LSB first under the tx handshake, report last byte), SHALL be instantiated; the FSM SHALL remain in the top module.

Verification
REQ-030 Reset during the third PC byte -> o_busy=0 and o_tx_start=0 next cycle; a new i_start produces a complete frame starting with 0xA5.
REQ-031 N_REGS=4, NB_DATA=32, MEM_DEPTH=8, i_pc=0x00000010, i_cycles=0x00000007, regs r0..r3=0x11223344·k, no dirty words, dump_all=0 -> 1+4+4+16+1 = 26 bytes, PC bytes 10 00 00 00, final byte equals XOR of bytes 2..25.
REQ-032 Same configuration with words 3 and 7 dirty (data 0xDEADBEEF, 0xCAFEF00D) -> records 03 EF BE AD DE and 07 0D F0 FE CA, 36 bytes total.
REQ-033 dump_all=1, MEM_DEPTH=8 -> exactly 8 memory records with addresses 00..07 in order, then checksum, one o_done pulse.
REQ-034 i_start asserted in REG_TX, plus a spurious i_tx_done while idle -> no frame restart, no extra bytes, byte count unchanged.
REQ-035 Random UART latency of 1..200 cycles per byte -> exactly one o_tx_start per i_tx_done, o_tx_data stable while outstanding.
